// File: rtl/conv_win_addr_gen_pkg.sv
// Shared definitions for the convolution window address generator:
// FSM state encoding, default kernel limit and stride limit.
package conv_win_addr_gen_pkg;

  localparam int unsigned KMAX_DEF   = 5;
  localparam int unsigned KSIZE_BIT  = 3;
  localparam int unsigned STRIDE_MAX = 3;
  localparam int unsigned STRIDE_BIT = $clog2(STRIDE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_win_addr_gen_win_pos_counter.sv
// win_pos_counter: stride-stepped wrap counter for one window axis.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                zero the position and capture stride/ksize/limit
//   step                advance by stride, or wrap to 0 when at_end
//   stride_in, ksize_in, limit_in   configuration captured on load
//   cnt                 current position (registered)
//   at_end              no further window fits after cnt (registered)
//   at_end_nxt_c        value at_end takes on the next clock edge
module win_pos_counter
  import conv_win_addr_gen_pkg::*;
#(
  parameter int unsigned DIM_BIT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [STRIDE_BIT-1:0] stride_in,
  input  logic [KSIZE_BIT-1:0]  ksize_in,
  input  logic [DIM_BIT-1:0]    limit_in,
  output logic [DIM_BIT-1:0]    cnt,
  output logic                  at_end,
  output logic                  at_end_nxt_c
);

  localparam int unsigned EW = DIM_BIT + 2;

  logic [STRIDE_BIT-1:0] stride_q;
  logic [KSIZE_BIT-1:0]  ksize_q;
  logic [DIM_BIT-1:0]    limit_q;
  logic [DIM_BIT-1:0]    cnt_nxt_c;

  // True when the window after pos would overrun the axis
  function automatic logic past_end(input logic [DIM_BIT-1:0]    pos,
                                    input logic [STRIDE_BIT-1:0] s,
                                    input logic [KSIZE_BIT-1:0]  k,
                                    input logic [DIM_BIT-1:0]    lim);
    return (EW'(pos) + EW'(s) + EW'(k)) > EW'(lim);
  endfunction

  // Next position and its end flag
  always_comb begin
    cnt_nxt_c    = cnt;
    at_end_nxt_c = at_end;
    if (load) begin
      cnt_nxt_c    = '0;
      at_end_nxt_c = past_end('0, stride_in, ksize_in, limit_in);
    end else if (step) begin
      cnt_nxt_c    = at_end ? '0 : cnt + DIM_BIT'(stride_q);
      at_end_nxt_c = past_end(cnt_nxt_c, stride_q, ksize_q, limit_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      at_end   <= 1'b0;
      stride_q <= '0;
      ksize_q  <= '0;
      limit_q  <= '0;
    end else begin
      cnt    <= cnt_nxt_c;
      at_end <= at_end_nxt_c;
      if (load) begin
        stride_q <= stride_in;
        ksize_q  <= ksize_in;
        limit_q  <= limit_in;
      end
    end
  end

endmodule

// File: rtl/conv_win_addr_gen.sv
// conv_win_addr_gen: sweeps a kernel window over a channel-major feature map
// and emits the start address of every kernel row of the current window.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a sweep with width/height/channel/ksize/stride
//   out_valid / out_ready    window handshake (transfer = valid & ready)
//   addr_rows                KMAX row addresses, slice k at [k*BRAM_ADDR_BIT +: BRAM_ADDR_BIT]
//   col_cnt/row_cnt/channel_cnt  current window position
//   out_last                 current window is the final one
//   busy, done, cfg_err      status; done and cfg_err are one-cycle pulses
module conv_win_addr_gen
  import conv_win_addr_gen_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_BIT = 32,
  parameter int unsigned DIM_BIT       = 12,
  parameter int unsigned KMAX          = KMAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DIM_BIT-1:0]            width,
  input  logic [DIM_BIT-1:0]            height,
  input  logic [DIM_BIT-1:0]            channel,
  input  logic [KSIZE_BIT-1:0]          ksize,
  input  logic [STRIDE_BIT-1:0]         stride,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [KMAX*BRAM_ADDR_BIT-1:0] addr_rows,
  output logic [DIM_BIT-1:0]            col_cnt,
  output logic [DIM_BIT-1:0]            row_cnt,
  output logic [DIM_BIT-1:0]            channel_cnt,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int unsigned AW = BRAM_ADDR_BIT;

  conv_state_e state;

  // Captured configuration and derived address steps
  logic [KSIZE_BIT-1:0]  ksize_q;
  logic [STRIDE_BIT-1:0] stride_q;
  logic [DIM_BIT-1:0]    channel_q;
  logic [AW-1:0]         plane_q;
  logic [AW-1:0]         stride_w_q;
  logic [AW-1:0]         koff_q [KMAX];

  // Base of the current channel plane and of the current window's top row
  logic [AW-1:0] chan_base;
  logic [AW-1:0] row_base;

  logic          cfg_bad_c, load_c, xfer_c;
  logic          step_col_c, step_row_c, chan_wrap_c;
  logic          col_at_end, row_at_end, col_end_nxt_c, row_end_nxt_c;
  logic          last_nxt_c;
  logic [DIM_BIT-1:0] chan_cnt_nxt_c, chan_lim_c;
  logic [AW-1:0] koff_in_c [KMAX];
  logic [AW-1:0] plane_in_c, stride_w_in_c, row_base_nxt_c, chan_step_c;

  // Handshake, config check and next-position bookkeeping
  always_comb begin
    cfg_bad_c = (ksize == '0) || (32'(ksize) > KMAX) || (stride == '0) ||
                (channel == '0) || (DIM_BIT'(ksize) > width) ||
                (DIM_BIT'(ksize) > height);
    load_c      = (state == ST_IDLE) && start && !cfg_bad_c;
    xfer_c      = out_valid && out_ready;
    step_col_c  = xfer_c && !out_last;
    step_row_c  = step_col_c && col_at_end;
    chan_wrap_c = step_row_c && row_at_end;

    chan_cnt_nxt_c = channel_cnt;
    if (load_c) begin
      chan_cnt_nxt_c = '0;
    end else if (chan_wrap_c) begin
      chan_cnt_nxt_c = channel_cnt + DIM_BIT'(1);
    end
    chan_lim_c = load_c ? channel : channel_q;
    last_nxt_c = col_end_nxt_c && row_end_nxt_c &&
                 (chan_cnt_nxt_c == chan_lim_c - DIM_BIT'(1));

    plane_in_c    = AW'(width) * AW'(height);
    stride_w_in_c = AW'(stride) * AW'(width);
    for (int k = 0; k < KMAX; k++) begin
      koff_in_c[k] = AW'(k) * AW'(width);
    end

    chan_step_c    = chan_base + plane_q;
    row_base_nxt_c = chan_wrap_c ? chan_step_c : row_base + stride_w_q;
  end

  win_pos_counter #(.DIM_BIT(DIM_BIT)) u_col (
    .clk          (clk),
    .rst          (rst),
    .load         (load_c),
    .step         (step_col_c),
    .stride_in    (stride),
    .ksize_in     (ksize),
    .limit_in     (width),
    .cnt          (col_cnt),
    .at_end       (col_at_end),
    .at_end_nxt_c (col_end_nxt_c)
  );

  win_pos_counter #(.DIM_BIT(DIM_BIT)) u_row (
    .clk          (clk),
    .rst          (rst),
    .load         (load_c),
    .step         (step_row_c),
    .stride_in    (stride),
    .ksize_in     (ksize),
    .limit_in     (height),
    .cnt          (row_cnt),
    .at_end       (row_at_end),
    .at_end_nxt_c (row_end_nxt_c)
  );

  // Control FSM with registered outputs and incremental address update
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      channel_cnt <= '0;
      addr_rows   <= '0;
      ksize_q     <= '0;
      stride_q    <= '0;
      channel_q   <= '0;
      plane_q     <= '0;
      stride_w_q  <= '0;
      chan_base   <= '0;
      row_base    <= '0;
      for (int k = 0; k < KMAX; k++) begin
        koff_q[k] <= '0;
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && cfg_bad_c) begin
            cfg_err <= 1'b1;
          end else if (load_c) begin
            state       <= ST_RUN;
            busy        <= 1'b1;
            out_valid   <= 1'b1;
            out_last    <= last_nxt_c;
            ksize_q     <= ksize;
            stride_q    <= stride;
            channel_q   <= channel;
            plane_q     <= plane_in_c;
            stride_w_q  <= stride_w_in_c;
            channel_cnt <= '0;
            chan_base   <= '0;
            row_base    <= '0;
            for (int k = 0; k < KMAX; k++) begin
              koff_q[k] <= koff_in_c[k];
              addr_rows[k*AW +: AW] <= (k < int'(ksize)) ? koff_in_c[k] : '0;
            end
          end
        end
        ST_RUN: begin
          if (step_col_c) begin
            channel_cnt <= chan_cnt_nxt_c;
            out_last    <= last_nxt_c;
            if (!col_at_end) begin
              // Same row band: every kernel row slides right by stride
              for (int k = 0; k < KMAX; k++) begin
                if (k < int'(ksize_q)) begin
                  addr_rows[k*AW +: AW] <= addr_rows[k*AW +: AW] + AW'(stride_q);
                end
              end
            end else begin
              // Column wrapped: rebuild rows from the new top-row base
              row_base <= row_base_nxt_c;
              if (chan_wrap_c) begin
                chan_base <= chan_step_c;
              end
              for (int k = 0; k < KMAX; k++) begin
                if (k < int'(ksize_q)) begin
                  addr_rows[k*AW +: AW] <= row_base_nxt_c + koff_q[k];
                end
              end
            end
          end else if (xfer_c) begin
            state     <= ST_DONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Scoreboard bench for conv_win_addr_gen: each accepted start queues the
// full list of expected windows; a negedge monitor pops on every transfer.
module tb_conv_win_addr_gen;

  localparam int AW = 32;
  localparam int DW = 12;
  localparam int KM = 5;
  localparam int VW = KM * AW;

  logic          clk, rst, start, out_ready;
  logic [DW-1:0] width, height, channel;
  logic [2:0]    ksize;
  logic [1:0]    stride;
  logic          out_valid, out_last, busy, done, cfg_err;
  logic [VW-1:0] addr_rows;
  logic [DW-1:0] col_cnt, row_cnt, channel_cnt;

  conv_win_addr_gen #(.BRAM_ADDR_BIT(AW), .DIM_BIT(DW), .KMAX(KM)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .width       (width),
    .height      (height),
    .channel     (channel),
    .ksize       (ksize),
    .stride      (stride),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .addr_rows   (addr_rows),
    .col_cnt     (col_cnt),
    .row_cnt     (row_cnt),
    .channel_cnt (channel_cnt),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] col, row, ch;
    logic          last;
    logic [VW-1:0] addrs;
  } win_t;

  win_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pops    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: enumerate every window position and its row addresses directly
  task automatic build(input int w, h, c, k, s, output int n);
    int   xs[$], ys[$];
    win_t e;
    n = 0;
    for (int x = 0; x + k <= w; x += s) xs.push_back(x);
    for (int y = 0; y + k <= h; y += s) ys.push_back(y);
    for (int ch = 0; ch < c; ch++)
      foreach (ys[yi])
        foreach (xs[xi]) begin
          e.col   = DW'(xs[xi]);
          e.row   = DW'(ys[yi]);
          e.ch    = DW'(ch);
          e.last  = (ch == c - 1) && (yi == ys.size() - 1) && (xi == xs.size() - 1);
          e.addrs = '0;
          for (int kk = 0; kk < k; kk++)
            e.addrs[kk*AW +: AW] = 32'(ch * w * h + (ys[yi] + kk) * w + xs[xi]);
          sb_q.push_back(e);
          n++;
        end
  endtask

  // Monitor: checks held outputs under backpressure and each transferred window
  logic [197:0] cur, held;
  bit           stall = 0;
  assign cur = {out_valid, out_last, col_cnt, row_cnt, channel_cnt, addr_rows};

  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) chk("hold", 256'(cur), 256'(held));
      stall = 0;
      if (out_valid) begin
        held = cur;
        if (!out_ready) begin
          stall = 1;
        end else begin
          pops++;
          if (sb_q.size() == 0) begin
            chk("extra_window", 1, 0);
          end else begin
            win_t e;
            e = sb_q.pop_front();
            chk("window", 256'({col_cnt, row_cnt, channel_cnt, out_last, addr_rows}),
                          256'({e.col, e.row, e.ch, e.last, e.addrs}));
          end
        end
      end
    end
  end

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      default: return !(cyc >= 1 && cyc <= 3);
    endcase
  endfunction

  task automatic scramble();
    width   = DW'($urandom_range(0, 15));
    height  = DW'($urandom_range(0, 15));
    channel = DW'($urandom_range(0, 3));
    ksize   = 3'($urandom_range(0, 7));
    stride  = 2'($urandom_range(0, 3));
  endtask

  task automatic set_cfg(input int w, h, c, k, s);
    width = DW'(w); height = DW'(h); channel = DW'(c);
    ksize = 3'(k);  stride = 2'(s);
  endtask

  task automatic sweep(input int w, h, c, k, s, mode, input bit noise);
    int n, p0;
    bit bad, seen;
    bad = (k == 0) || (k > KM) || (s == 0) || (c == 0) || (k > w) || (k > h);
    n = 0;
    if (!bad) build(w, h, c, k, s, n);
    p0 = pops;
    @(posedge clk); #1;
    set_cfg(w, h, c, k, s);
    start = 1; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    if (noise) scramble();
    if (bad) begin
      @(negedge clk);
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_idle", {out_valid, busy}, 0);
      @(negedge clk);
      chk("cfg_err_clear", {cfg_err, out_valid, busy}, 0);
      return;
    end
    out_ready = rdy(mode, 0);
    @(negedge clk);
    chk("first_valid", {out_valid, busy, col_cnt, row_cnt, channel_cnt}, 2'b11 << (3*DW));
    seen = 0;
    for (int cyc = 1; cyc < 4000 && !seen; cyc++) begin
      @(posedge clk); #1;
      out_ready = rdy(mode, cyc);
      if (noise) begin
        start = ($urandom_range(0, 5) == 0);
        scramble();
      end
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("done_state", {busy, out_valid}, 2'b10);
    chk("win_count", pops - p0, n);
    chk("queue_empty", sb_q.size(), 0);
    // A legal start during DONE must be ignored
    set_cfg(w, h, c, k, s);
    start = noise;
    @(negedge clk);
    start = 0;
    chk("done_clear", {done, busy, out_valid, cfg_err}, 0);
    sb_q.delete();
  endtask

  task automatic reset_mid_run();
    int n, p0, cyc;
    build(5, 5, 1, 3, 1, n);
    p0 = pops;
    @(posedge clk); #1;
    set_cfg(5, 5, 1, 3, 1);
    start = 1; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (pops - p0 < 3 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("rst_reach", pops - p0, 3);
    @(posedge clk); #1;
    chk("rst_window4", {out_valid, col_cnt, row_cnt, addr_rows[3*AW-1:0]},
        {1'b1, DW'(0), DW'(1), 32'd15, 32'd10, 32'd5});
    rst = 1; start = 1; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 256'(cur), 0);
    chk("rst_status", {busy, done, cfg_err}, 0);
    rst = 0; start = 0; out_ready = 1;
    @(negedge clk);
    chk("rst_idle", {out_valid, busy}, 0);
    sb_q.delete();
  endtask

  initial begin
    rst = 1; start = 0; out_ready = 0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 256'(cur), 0);
    chk("reset_status", {busy, done, cfg_err}, 0);
    rst = 0;

    sweep(5, 5, 1, 3, 1, 0, 0);
    sweep(5, 5, 1, 3, 2, 0, 0);
    sweep(4, 4, 2, 3, 1, 0, 0);
    sweep(5, 5, 1, 3, 1, 2, 0);
    sweep(3, 5, 1, 4, 1, 0, 0);
    sweep(5, 5, 3, 5, 3, 1, 1);
    sweep(6, 6, 0, 2, 1, 0, 0);
    sweep(6, 6, 1, 2, 0, 0, 0);
    reset_mid_run();
    sweep(5, 5, 1, 3, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      int w, h, c, k, s;
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 8);
      c = $urandom_range(0, 3);
      k = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
      s = $urandom_range(0, 3);
      sweep(w, h, c, k, s, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_win_addr_gen.md
CONV_WIN_ADDR_GEN -- requirements
Module: conv_win_addr_gen

Interface
REQ-001 Parameter BRAM_ADDR_BIT, 32, width of every generated address.
REQ-002 Parameter DIM_BIT, 12, width of width/height/channel/counter fields.
REQ-003 Parameter KMAX, 5, largest supported kernel size (row addresses per window).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  pulse; latches configuration and begins a feature-map sweep.
REQ-007 width, height  input  DIM_BIT each  feature-map columns and rows.
REQ-008 channel  input  DIM_BIT  number of input channels.
REQ-009 ksize  input  3  kernel size, 1..KMAX.
REQ-010 stride  input  2  window step, 1..3.
REQ-011 out_valid  output  1  window addresses valid.
REQ-012 out_ready  input  1  consumer accepts the current window.
REQ-013 addr_rows  output  KMAX*BRAM_ADDR_BIT  row k start address in slice k (k=0 in LSBs).
REQ-014 col_cnt, row_cnt, channel_cnt  output  DIM_BIT each  current window position.
REQ-015 out_last  output  1  current window is the final one of the sweep.
REQ-016 busy  output  1  sweep in progress; done  output  1  one-cycle end pulse; cfg_err  output  1  one-cycle bad-config pulse.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IDLE->RUN on start with legal config, RUN->DONE on the transfer of the out_last window, DONE->IDLE unconditionally after one cycle.
REQ-018 Configuration is captured on the accepting start cycle; input changes during RUN have no effect.
REQ-019 start while busy or in DONE is ignored.
REQ-020 Illegal config (ksize 0 or >KMAX, stride 0, channel 0, ksize>width, ksize>height) pulses cfg_err for one cycle, produces no window, and leaves the FSM in IDLE.
REQ-021 First window (0,0,channel 0) is presented with out_valid high on the cycle after start.
REQ-022 addr_rows slice k = channel_cnt*width*height + (row_cnt+k)*width + col_cnt for k<ksize; slices k>=ksize are 0.
REQ-023 A transfer is out_valid & out_ready; each transfer advances the position with one window per cycle maximum.
REQ-024 While out_valid & !out_ready, all outputs hold stable.
REQ-025 Column advance: col+=stride; if col+stride+ksize>width then col=0 and row advances.
REQ-026 Row advance: row+=stride; if row+stride+ksize>height then row=0 and channel advances.
REQ-027 Channel advance: channel+=1; the window at channel-1 with both column and row at final position is out_last.
REQ-028 Addresses update incrementally (adders; plane size width*height computed once at start); arithmetic wraps modulo 2^BRAM_ADDR_BIT.
REQ-029 busy high in RUN and DONE; done high only in DONE; out_valid high only in RUN.

Reset
REQ-030 On rst (any state, including mid-sweep): FSM IDLE; out_valid, out_last, busy, done, cfg_err 0; all counters and addr_rows 0; captured config 0.
REQ-031 rst dominates start in the same cycle.

Structure
REQ-032 FSM state encodings, KMAX default and stride limit belong in the shared conv package.
REQ-033 One sub-module, win_pos_counter (stride-stepped wrap counter with end flag), instantiated for column and row.

Verification
REQ-034 width=5,height=5,ksize=3,stride=1,channel=1,ready=1 -> 9 windows; first addr_rows 0,5,10; last 12,17,22 with out_last; done 1 cycle later.
REQ-035 Same with stride=2 -> 4 windows at (col,row) (0,0),(2,0),(0,2),(2,2); addresses 0/5/10, 2/7/12, 10/15/20, 12/17/22.
REQ-036 width=4,height=4,ksize=3,stride=1,channel=2 -> 8 windows; 5th window channel_cnt=1, addr_rows 16,20,24.
REQ-037 Backpressure: out_ready low 3 cycles on window 2 -> outputs unchanged for those cycles, no window skipped or repeated.
REQ-038 ksize=4,width=3 -> cfg_err one cycle, out_valid never asserted, busy stays 0.
REQ-039 rst asserted at window 4 of REQ-034 run -> next cycle all outputs 0, IDLE; a new start re-sweeps from window (0,0).
